rtc_offset_seq: RTL
===================

Name: rtc_offset_seq

Overview:
- Bus-master sequencer and arbiter in front of the RTC register slave on the 32-bit on-chip bus.
- Shares that bus between the host CPU and a hardware servo.
- The servo hands over one 80-bit time offset per handshake. The block turns it into an ordered, atomic register sequence:
  - read RTC control
  - write seconds offset high
  - write seconds offset low
  - write nanoseconds offset
  - write RTC control with offset_valid=1 while preserving intxms_sel
- It then holds off until the slave's self-clearing offset_valid pulse has completed.

Parameters:
- BLK_ADDR, `RTC_BLK_ADDR, 24-bit block base compared against addr[31:8].
- HOLD_CYC, 4, number of host-write-free cycles to wait after the control write before the next request is accepted (1..15).

Ports:
- bus2ip_clk  in  1  clock; all logic on rising edge.
- bus2ip_rst  in  1  synchronous reset, active-high.
- host_addr_i  in  32  host address.
- host_data_i  in  32  host write data.
- host_rd_ce_i  in  1  host read strobe, single cycle, never stalled.
- host_wr_ce_i  in  1  host write strobe, single cycle, never stalled.
- host_data_o  out  32  read data to host; combinational copy of ip2bus_data_i.
- adj_valid_i  in  1  servo offset request.
- adj_ready_o  out  1  request accepted when adj_valid_i & adj_ready_o.
- adj_sc_i  in  48  seconds offset.
- adj_ns_i  in  32  nanoseconds offset.
- adj_done_o  out  1  one-cycle pulse in the cycle the control write is issued.
- conflict_o  out  1  sticky: a sequence was restarted because of a host write.
- bus2ip_addr_o  out  32  address to the RTC slave.
- bus2ip_data_o  out  32  write data to the RTC slave.
- bus2ip_rd_ce_o  out  1  read strobe to the RTC slave.
- bus2ip_wr_ce_o  out  1  write strobe to the RTC slave.
- ip2bus_data_i  in  32  slave read data, valid one cycle after the read strobe.

Behaviour:
- Reset:
  - state=IDLE, adj_ready_o=1, adj_done_o=0, conflict_o=0.
  - Latched offset, captured intxms bit and hold counter all 0.
- Arbitration:
  - host_act = host_rd_ce_i | host_wr_ce_i.
  - When host_act=1, all bus2ip_*_o are a combinational pass-through of the host inputs, and the sequencer issues nothing that cycle.
  - Otherwise the sequencer drives the bus in its issuing states and drives strobes 0 elsewhere.
  - Host has strict priority and zero added latency.
- "Issue" means the sequencer strobe is driven in a cycle with host_act=0. A state advances only on issue, so a blocked issue is retried the next cycle.
- FSM states: IDLE, RD_CTL, CAP_CTL, WR_SCH, WR_SCL, WR_NS, WR_CTL, HOLD.
  - IDLE: adj_ready_o=1. On handshake, latch adj_sc_i/adj_ns_i, clear conflict_o, go to RD_CTL.
  - RD_CTL: issue read of {BLK_ADDR,`RTC_CTL_ADDR}, then go to CAP_CTL.
  - CAP_CTL: unconditionally capture ip2bus_data_i[2] as intxms, then go to WR_SCH. No bus access in this state.
  - WR_SCH: write {16'h0, sc[47:32]} to `SC_OFST_ADDR0.
  - WR_SCL: write sc[31:0] to `SC_OFST_ADDR1.
  - WR_NS: write ns to `NS_OFST_ADDR.
  - WR_CTL: write {29'h0, intxms, 1'b0, 1'b1} to `RTC_CTL_ADDR. Pulse adj_done_o, clear the hold counter, go to HOLD.
  - HOLD: increment the counter on each cycle with host_wr_ce_i=0. At count==HOLD_CYC go to IDLE.
    - Rationale: slave self-clear is blocked during bus writes, and a re-write of offset_valid before it clears would not retrigger.
- adj_ready_o=0 in every state except IDLE. The servo must hold its inputs only until the handshake.
- Conflict: in states CAP_CTL, WR_SCH, WR_SCL, WR_NS, a host write decoded to BLK_ADDR with offset in {RTC_CTL, SC_OFST0, SC_OFST1, NS_OFST}:
  - next state=RD_CTL; conflict_o set.
  - The latched offset is kept and the full sequence is replayed.
  - Host writes to other addresses or blocks never cause a restart.
- Host writes in RD_CTL, WR_CTL or HOLD do not restart the sequence.
- Read data return: a host read issued in RD_CTL's issuing cycle is impossible, because host has priority. host_data_o therefore always returns the data for whichever read was on the bus the previous cycle.
- Reset mid-sequence: immediate return to IDLE; partially written offset registers in the slave are left as-is.
- Latency, no host traffic: 6 cycles from handshake to the control write (RD, CAP, 4 writes). adj_ready_o returns HOLD_CYC cycles later.

Decomposition:
- Address offsets and BLK_ADDR come from the shared ptpv2_defines.v macros.
- Add there: `RTC_CTL_OFST_VLD_BIT=0, `RTC_CTL_CLR_BIT=1, `RTC_CTL_INTXMS_BIT=2.
- FSM state encodings are local parameters.
- No sub-module; single flat block.

Test Plan:
- Idle host, adj_sc=48'h0000_0001_0002, adj_ns=32'h1234_5678, slave CTL reads 32'h4:
  - writes SC0=32'h0000_0000, SC1=32'h0001_0002, NS=32'h1234_5678, CTL=32'h5 on consecutive cycles.
  - adj_done_o pulses once; slave offset_valid_o pulses exactly once; adj_ready_o is high again after HOLD_CYC=4 cycles.
- Host read of CUR_TM_ADDR1 in the same cycle as RD_CTL: host address is passed through and its data is returned next cycle; the sequencer read slips one cycle; order and values are unchanged.
- Host write to NS_OFST during WR_SCL: conflict_o=1; the sequence replays from RD_CTL; final slave ns_offset equals the servo value 32'h1234_5678.
- Host write to TICK_INC during WR_NS: no restart, conflict_o stays 0, tick_inc is updated.
- Back-to-back requests with host writing PPS_W every other cycle during HOLD: the second request waits until 4 write-free cycles have elapsed; both requests produce separate offset_valid_o pulses.
- Assert bus2ip_rst during WR_NS: outputs return to reset values next cycle; no further writes; a new request is accepted afterwards.

Source files
------------

// File: rtl/rtc_offset_seq_pkg.sv
// rtc_offset_seq_pkg: RTC register map, control bit positions and sequencer state type
package rtc_offset_seq_pkg;
  localparam logic [23:0] RTC_BLK_ADDR = 24'h00_0010;
  localparam logic [7:0] RTC_CTL_ADDR = 8'h00;
  localparam logic [7:0] SC_OFST_ADDR0 = 8'h04;
  localparam logic [7:0] SC_OFST_ADDR1 = 8'h08;
  localparam logic [7:0] NS_OFST_ADDR = 8'h0C;
  localparam logic [7:0] TICK_INC_ADDR = 8'h10;
  localparam logic [7:0] CUR_TM_ADDR0 = 8'h14;
  localparam logic [7:0] CUR_TM_ADDR1 = 8'h18;
  localparam logic [7:0] PPS_W_ADDR = 8'h1C;
  localparam int RTC_CTL_OFST_VLD_BIT = 0;
  localparam int RTC_CTL_CLR_BIT = 1;
  localparam int RTC_CTL_INTXMS_BIT = 2;
  typedef enum logic [2:0] {IDLE, RD_CTL, CAP_CTL, WR_SCH, WR_SCL, WR_NS, WR_CTL, HOLD} seq_state_t;
  function automatic logic ofst_reg(input logic [7:0] a);
    return a inside {RTC_CTL_ADDR, SC_OFST_ADDR0, SC_OFST_ADDR1, NS_OFST_ADDR};
  endfunction
endpackage

// File: rtl/rtc_offset_seq.sv
// rtc_offset_seq: host/servo bus arbiter issuing atomic RTC offset sequences (host pass-through, servo adj handshake, bus2ip master)
module rtc_offset_seq
  import rtc_offset_seq_pkg::*;
#(
  parameter logic [23:0] BLK_ADDR = RTC_BLK_ADDR,
  parameter int HOLD_CYC = 4
) (
  input  logic        bus2ip_clk,
  input  logic        bus2ip_rst,
  input  logic [31:0] host_addr_i,
  input  logic [31:0] host_data_i,
  input  logic        host_rd_ce_i,
  input  logic        host_wr_ce_i,
  output logic [31:0] host_data_o,
  input  logic        adj_valid_i,
  output logic        adj_ready_o,
  input  logic [47:0] adj_sc_i,
  input  logic [31:0] adj_ns_i,
  output logic        adj_done_o,
  output logic        conflict_o,
  output logic [31:0] bus2ip_addr_o,
  output logic [31:0] bus2ip_data_o,
  output logic        bus2ip_rd_ce_o,
  output logic        bus2ip_wr_ce_o,
  input  logic [31:0] ip2bus_data_i
);
  seq_state_t state, state_nxt;
  logic [47:0] sc;
  logic [31:0] ns;
  logic intxms;
  logic [3:0] cnt, cnt_nxt;
  logic host_act, conf, seq_rd, seq_wr, issue;
  logic [7:0] seq_ofst;
  logic [31:0] seq_data;
  always_comb begin
    host_act = host_rd_ce_i | host_wr_ce_i;
    conf = host_wr_ce_i && host_addr_i[31:8] == BLK_ADDR && ofst_reg(host_addr_i[7:0])
      && state inside {CAP_CTL, WR_SCH, WR_SCL, WR_NS};
    seq_rd = state == RD_CTL;
    seq_wr = state inside {WR_SCH, WR_SCL, WR_NS, WR_CTL};
    seq_ofst = state == WR_SCH ? SC_OFST_ADDR0 : state == WR_SCL ? SC_OFST_ADDR1
      : state == WR_NS ? NS_OFST_ADDR : RTC_CTL_ADDR;
    seq_data = state == WR_SCH ? {16'h0, sc[47:32]} : state == WR_SCL ? sc[31:0]
      : state == WR_NS ? ns : state == WR_CTL ? {29'h0, intxms, 2'b01} : 32'h0;
    issue = (seq_rd | seq_wr) & ~host_act;
    cnt_nxt = cnt + {3'b0, ~host_wr_ce_i};
    // the issuing states are consecutive in the encoding, so advancing is +1
    state_nxt = state == IDLE ? (adj_valid_i ? RD_CTL : IDLE)
      : state == HOLD ? (cnt_nxt == 4'(HOLD_CYC) ? IDLE : HOLD)
      : conf ? RD_CTL
      : (issue || state == CAP_CTL) ? seq_state_t'(state + 3'd1) : state;
    bus2ip_addr_o = host_act ? host_addr_i : {BLK_ADDR, seq_ofst};
    bus2ip_data_o = host_act ? host_data_i : seq_data;
    bus2ip_rd_ce_o = host_act ? host_rd_ce_i : seq_rd;
    bus2ip_wr_ce_o = host_act ? host_wr_ce_i : seq_wr;
    host_data_o = ip2bus_data_i;
    adj_ready_o = state == IDLE;
    adj_done_o = state == WR_CTL && issue;
  end
  always_ff @(posedge bus2ip_clk) begin
    if (bus2ip_rst) begin
      state <= IDLE;
      sc <= '0;
      ns <= '0;
      intxms <= 1'b0;
      cnt <= '0;
      conflict_o <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && adj_valid_i) begin
        sc <= adj_sc_i;
        ns <= adj_ns_i;
        conflict_o <= 1'b0;
      end
      if (conf) conflict_o <= 1'b1;
      if (state == CAP_CTL) intxms <= ip2bus_data_i[RTC_CTL_INTXMS_BIT];
      cnt <= state == HOLD ? cnt_nxt : 4'h0;
    end
  end
endmodule
